// File: rtl/code_msg_pkg.sv
// Shared constants and sizing helpers for the code/message player.
// Storage is packed 32 chips or bits per word, chip 32*w+b in bit b of word w.
package code_msg_pkg;

  localparam int DEF_CODE_LEN = 1023;
  localparam int DEF_MSG_LEN  = 1500;
  localparam int WORD_W       = 32;

  typedef enum logic {
    KIND_CODE = 1'b0,
    KIND_MSG  = 1'b1
  } wr_kind_e;

  function automatic int code_words(input int len);
    return (len + WORD_W - 1) / WORD_W;
  endfunction

  function automatic int msg_words(input int len);
    return (len + WORD_W - 1) / WORD_W;
  endfunction

  // Keeps degenerate $clog2 results from producing zero-width vectors.
  function automatic int min1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

endpackage

// File: rtl/code_msg_chan.sv
// One playback channel: chip/epoch/bit counters, delay shadow, code and
// message RAMs, and the registered chip/bit/epoch outputs.
module code_msg_chan
  import code_msg_pkg::*;
#(
  parameter int CODE_LEN       = DEF_CODE_LEN,
  parameter int MSG_LEN        = DEF_MSG_LEN,
  parameter int EPOCHS_PER_BIT = 1,
  parameter int DLY_W          = 10,
  parameter int WA_W           = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              stb,
  input  logic [DLY_W-1:0]  delay,
  input  logic              wr_code,
  input  logic              wr_msg,
  input  logic [WA_W-1:0]   wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  output logic              data_ca,
  output logic              data_msg,
  output logic              epoch
);

  localparam int CODE_WORDS = code_words(CODE_LEN);
  localparam int MSG_WORDS  = msg_words(MSG_LEN);
  localparam int CWA_W      = min1($clog2(CODE_WORDS));
  localparam int MWA_W      = min1($clog2(MSG_WORDS));
  localparam int CC_W       = min1($clog2(CODE_LEN));
  localparam int EC_W       = min1($clog2(EPOCHS_PER_BIT));
  localparam int MI_W       = min1($clog2(MSG_LEN));
  localparam int IW         = DLY_W + 2;

  localparam logic [IW-1:0]   LEN_I  = IW'(CODE_LEN);
  localparam logic [CC_W-1:0] CC_MAX = CC_W'(CODE_LEN - 1);
  localparam logic [EC_W-1:0] EC_MAX = EC_W'(EPOCHS_PER_BIT - 1);
  localparam logic [MI_W-1:0] MI_MAX = MI_W'(MSG_LEN - 1);

  logic [WORD_W-1:0] code_mem [CODE_WORDS];
  logic [WORD_W-1:0] msg_mem  [MSG_WORDS];

  logic [CC_W-1:0]  cc;
  logic [EC_W-1:0]  ec;
  logic [MI_W-1:0]  mi;
  logic [DLY_W-1:0] shadow;
  logic             run;

  logic [DLY_W-1:0] live_d;
  logic [DLY_W-1:0] cur_d;
  logic [IW-1:0]    rd_sum;
  logic [IW-1:0]    rd_idx;
  logic [CWA_W-1:0] code_word;
  logic [4:0]       code_bit;
  logic [MWA_W-1:0] msg_word;
  logic [4:0]       msg_bit;

  // Until the first strobe after enable the live delay is used directly, so
  // the first chip already reflects the delay presented at start-up.
  always_comb begin
    live_d    = ({2'b00, delay} < LEN_I) ? delay : '0;
    cur_d     = run ? shadow : live_d;
    rd_sum    = IW'(cc) + (LEN_I - {2'b00, cur_d});
    rd_idx    = (rd_sum >= LEN_I) ? rd_sum - LEN_I : rd_sum;
    code_word = CWA_W'(rd_idx >> 5);
    code_bit  = 5'(rd_idx);
    msg_word  = MWA_W'(mi >> 5);
    msg_bit   = 5'(mi);
  end

  // Storage is deliberately outside reset so contents survive it.
  always_ff @(posedge clk) begin
    if (wr_code) code_mem[CWA_W'(wr_addr)] <= wr_data;
    if (wr_msg)  msg_mem[MWA_W'(wr_addr)]  <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cc       <= '0;
      ec       <= '0;
      mi       <= '0;
      shadow   <= '0;
      run      <= 1'b0;
      data_ca  <= 1'b0;
      data_msg <= 1'b0;
      epoch    <= 1'b0;
    end else if (!en) begin
      cc       <= '0;
      ec       <= '0;
      mi       <= '0;
      shadow   <= live_d;
      run      <= 1'b0;
      data_ca  <= 1'b0;
      data_msg <= 1'b0;
      epoch    <= 1'b0;
    end else begin
      epoch <= 1'b0;
      if (!run) shadow <= live_d;
      if (stb) begin
        run      <= 1'b1;
        data_ca  <= code_mem[code_word][code_bit];
        data_msg <= msg_mem[msg_word][msg_bit];
        if (cc == CC_MAX) begin
          cc     <= '0;
          epoch  <= 1'b1;
          shadow <= live_d;
          if (ec == EC_MAX) begin
            ec <= '0;
            mi <= (mi == MI_MAX) ? '0 : mi + 1'b1;
          end else begin
            ec <= ec + 1'b1;
          end
        end else begin
          cc <= cc + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/code_msg_player.sv
// Multi-channel spreading-code and message-bit player with a shared
// word-wide write port into per-channel code and message RAMs.
module code_msg_player
  import code_msg_pkg::*;
#(
  parameter int NUM_CH         = 8,
  parameter int CODE_LEN       = DEF_CODE_LEN,
  parameter int MSG_LEN        = DEF_MSG_LEN,
  parameter int EPOCHS_PER_BIT = 1,
  localparam int CODE_WORDS    = code_words(CODE_LEN),
  localparam int MSG_WORDS     = msg_words(MSG_LEN),
  localparam int DLY_W         = $clog2(CODE_LEN),
  localparam int WA_W          = min1($clog2((CODE_WORDS > MSG_WORDS) ? CODE_WORDS : MSG_WORDS)),
  localparam int CH_W          = min1($clog2(NUM_CH))
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic                    wr_kind,
  input  logic [CH_W-1:0]         wr_ch,
  input  logic [WA_W-1:0]         wr_addr,
  input  logic [WORD_W-1:0]       wr_data,
  output logic                    wr_err,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH-1:0]       chip_stb,
  input  logic [NUM_CH*DLY_W-1:0] delay,
  output logic [NUM_CH-1:0]       data_ca,
  output logic [NUM_CH-1:0]       data_msg,
  output logic [NUM_CH-1:0]       epoch
);

  localparam logic [CH_W:0] NCH_L   = (CH_W + 1)'(NUM_CH);
  localparam logic [WA_W:0] CWORD_L = (WA_W + 1)'(CODE_WORDS);
  localparam logic [WA_W:0] MWORD_L = (WA_W + 1)'(MSG_WORDS);

  wr_kind_e kind;
  logic     ch_ok;
  logic     addr_ok;
  logic     wr_take;
  logic     wr_bad;

  assign wr_ready = !rst;

  always_comb begin
    kind    = wr_kind_e'(wr_kind);
    ch_ok   = {1'b0, wr_ch} < NCH_L;
    addr_ok = (kind == KIND_MSG) ? ({1'b0, wr_addr} < MWORD_L)
                                 : ({1'b0, wr_addr} < CWORD_L);
    wr_take = wr_valid && wr_ready && ch_ok && addr_ok;
    wr_bad  = wr_valid && wr_ready && !(ch_ok && addr_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         wr_err <= 1'b0;
    else if (wr_bad) wr_err <= 1'b1;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    code_msg_chan #(
      .CODE_LEN       (CODE_LEN),
      .MSG_LEN        (MSG_LEN),
      .EPOCHS_PER_BIT (EPOCHS_PER_BIT),
      .DLY_W          (DLY_W),
      .WA_W           (WA_W)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .en       (ch_en[i]),
      .stb      (chip_stb[i]),
      .delay    (delay[i*DLY_W +: DLY_W]),
      .wr_code  (wr_take && (kind == KIND_CODE) && (wr_ch == CH_W'(i))),
      .wr_msg   (wr_take && (kind == KIND_MSG) && (wr_ch == CH_W'(i))),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .data_ca  (data_ca[i]),
      .data_msg (data_msg[i]),
      .epoch    (epoch[i])
    );
  end

endmodule

// File: tb/tb_code_msg_player.sv
// Randomised self-checking bench: a full-length 4-channel player plus a tiny
// 1-channel player (short code/message) to reach message wrap quickly.
module tb_code_msg_player;

  localparam int NCH = 4;
  localparam int BL  = 1023;
  localparam int BM  = 1500;
  localparam int SL  = 7;
  localparam int SM  = 3;
  localparam int EPB = 2;
  localparam int NU  = NCH + 1;
  localparam int BCW = (BL + 31) / 32;
  localparam int BMW = (BM + 31) / 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic             wr_valid, wr_ready, wr_kind, wr_err;
  logic [1:0]       wr_ch;
  logic [5:0]       wr_addr;
  logic [31:0]      wr_data;
  logic [NCH-1:0]   ch_en, chip_stb, data_ca, data_msg, epoch;
  logic [NCH*10-1:0] delay;

  logic        s_wr_valid, s_wr_ready, s_wr_kind, s_wr_err;
  logic [0:0]  s_wr_ch, s_wr_addr;
  logic [31:0] s_wr_data;
  logic [0:0]  s_ch_en, s_chip_stb, s_data_ca, s_data_msg, s_epoch;
  logic [2:0]  s_delay;

  code_msg_player #(.NUM_CH(NCH), .CODE_LEN(BL), .MSG_LEN(BM), .EPOCHS_PER_BIT(EPB)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_kind(wr_kind),
    .wr_ch(wr_ch), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err),
    .ch_en(ch_en), .chip_stb(chip_stb), .delay(delay),
    .data_ca(data_ca), .data_msg(data_msg), .epoch(epoch)
  );

  code_msg_player #(.NUM_CH(1), .CODE_LEN(SL), .MSG_LEN(SM), .EPOCHS_PER_BIT(EPB)) dut_s (
    .clk(clk), .rst(rst), .wr_valid(s_wr_valid), .wr_ready(s_wr_ready), .wr_kind(s_wr_kind),
    .wr_ch(s_wr_ch), .wr_addr(s_wr_addr), .wr_data(s_wr_data), .wr_err(s_wr_err),
    .ch_en(s_ch_en), .chip_stb(s_chip_stb), .delay(s_delay),
    .data_ca(s_data_ca), .data_msg(s_data_msg), .epoch(s_epoch)
  );

  // Reference model: chips played since start, delay in force for the current epoch.
  bit code_bits [NU][1024];
  bit msg_bits  [NU][1500];
  int k [NU];
  int dcur [NU];
  bit running [NU];
  bit e_ca [NU];
  bit e_msg [NU];
  bit e_ep [NU];
  bit e_err, e_s_err;
  int vectors, miscompares;

  function automatic int ulen(input int u);
    return (u < NCH) ? BL : SL;
  endfunction

  function automatic int umlen(input int u);
    return (u < NCH) ? BM : SM;
  endfunction

  function automatic int ulive(input int u);
    int d;
    if (u < NCH) d = int'(delay[u*10 +: 10]);
    else d = int'(s_delay);
    return (d >= ulen(u)) ? 0 : d;
  endfunction

  function automatic bit uen(input int u);
    if (u < NCH) return ch_en[u];
    return s_ch_en[0];
  endfunction

  function automatic bit ustb(input int u);
    if (u < NCH) return chip_stb[u];
    return s_chip_stb[0];
  endfunction

  task automatic modelReset();
    for (int u = 0; u < NU; u++) begin
      k[u] = 0; running[u] = 0; dcur[u] = 0;
      e_ca[u] = 0; e_msg[u] = 0; e_ep[u] = 0;
    end
    e_err = 0; e_s_err = 0;
  endtask

  task automatic modelWrite(input int u, input bit kind, input int addr, input logic [31:0] data);
    for (int b = 0; b < 32; b++) begin
      if (!kind && (32*addr + b) < ulen(u)) code_bits[u][32*addr + b] = data[b];
      if (kind && (32*addr + b) < umlen(u)) msg_bits[u][32*addr + b] = data[b];
    end
  endtask

  task automatic modelStep();
    for (int u = 0; u < NU; u++) begin
      if (!uen(u)) begin
        k[u] = 0; running[u] = 0;
        e_ca[u] = 0; e_msg[u] = 0; e_ep[u] = 0;
      end else begin
        e_ep[u] = 0;
        if (ustb(u)) begin
          int c;
          c = k[u] % ulen(u);
          if (!running[u]) begin dcur[u] = ulive(u); running[u] = 1; end
          e_ca[u]  = code_bits[u][(c - dcur[u] + ulen(u)) % ulen(u)];
          e_msg[u] = msg_bits[u][(k[u] / ulen(u) / EPB) % umlen(u)];
          if (c == ulen(u) - 1) begin e_ep[u] = 1; dcur[u] = ulive(u); end
          k[u]++;
        end
      end
    end
    if (wr_valid) begin
      if (int'(wr_addr) < (wr_kind ? BMW : BCW)) modelWrite(int'(wr_ch), wr_kind, int'(wr_addr), wr_data);
      else e_err = 1;
    end
    if (s_wr_valid) begin
      if (s_wr_ch == 1'b0 && s_wr_addr == 1'b0) modelWrite(NCH, s_wr_kind, 0, s_wr_data);
      else e_s_err = 1;
    end
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    for (int u = 0; u < NU; u++) begin
      logic oc, om, oe;
      if (u < NCH) begin oc = data_ca[u]; om = data_msg[u]; oe = epoch[u]; end
      else begin oc = s_data_ca[0]; om = s_data_msg[0]; oe = s_epoch[0]; end
      checkVal($sformatf("data_ca[u%0d]", u), oc, e_ca[u]);
      checkVal($sformatf("data_msg[u%0d]", u), om, e_msg[u]);
      checkVal($sformatf("epoch[u%0d]", u), oe, e_ep[u]);
    end
    checkVal("wr_err", wr_err, e_err);
    checkVal("s_wr_err", s_wr_err, e_s_err);
  endtask

  // One clock: inputs are already set (at negedge), model follows the edge,
  // outputs are checked 1 time unit later, pulsed inputs are cleared.
  task automatic applyStimulus();
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
    @(negedge clk);
    chip_stb = '0; s_chip_stb = '0; wr_valid = 1'b0; s_wr_valid = 1'b0;
  endtask

  task automatic writeBig(input bit kind, input int ch, input int addr, input logic [31:0] data);
    wr_valid = 1'b1; wr_kind = kind; wr_ch = 2'(ch); wr_addr = 6'(addr); wr_data = data;
    applyStimulus();
  endtask

  task automatic writeSmall(input bit kind, input bit ch, input bit addr, input logic [31:0] data);
    s_wr_valid = 1'b1; s_wr_kind = kind; s_wr_ch = ch; s_wr_addr = addr; s_wr_data = data;
    applyStimulus();
  endtask

  task automatic strobe(input logic [NCH-1:0] m, input logic s);
    chip_stb = m; s_chip_stb = s;
    applyStimulus();
  endtask

  task automatic checkAllZero(input string tag);
    checkVal({tag, "_ca"}, data_ca, 0);
    checkVal({tag, "_msg"}, data_msg, 0);
    checkVal({tag, "_epoch"}, epoch, 0);
    checkVal({tag, "_ready"}, wr_ready, 0);
    checkVal({tag, "_err"}, wr_err, 0);
    checkVal({tag, "_s_out"}, {s_data_ca, s_data_msg, s_epoch, s_wr_ready, s_wr_err}, 0);
  endtask

  initial begin
    int pulses;
    logic [2:0] pat;
    vectors = 0; miscompares = 0;
    rst = 1'b1;
    wr_valid = 0; wr_kind = 0; wr_ch = 0; wr_addr = 0; wr_data = 0;
    ch_en = 0; chip_stb = 0; delay = 0;
    s_wr_valid = 0; s_wr_kind = 0; s_wr_ch = 0; s_wr_addr = 0; s_wr_data = 0;
    s_ch_en = 0; s_chip_stb = 0; s_delay = 0;
    modelReset();
    #1;
    checkAllZero("reset");
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkVal("wr_ready_after_reset", {wr_ready, s_wr_ready}, 2'b11);

    // Random storage contents for every channel.
    for (int ch = 0; ch < NCH; ch++) begin
      for (int w = 0; w < BCW; w++) writeBig(0, ch, w, $urandom);
      for (int w = 0; w < BMW; w++) writeBig(1, ch, w, $urandom);
    end
    writeSmall(0, 0, 0, $urandom);
    writeSmall(1, 0, 0, $urandom);

    // Code word 0 = 5 on ch0, zero delay: chips 1,0,1.
    writeBig(0, 0, 0, 32'h0000_0005);
    delay[9:0] = 10'd0;
    ch_en[0] = 1'b1;
    applyStimulus();
    pat = 3'b101;
    for (int j = 0; j < 3; j++) begin
      strobe(4'b0001, 1'b0);
      checkVal($sformatf("ch0_chip%0d", j), data_ca[0], pat[j]);
    end

    // ch1: only chip 1021 set, delay 2; one epoch pulse per 1023 strobes.
    for (int w = 0; w < BCW; w++) writeBig(0, 1, w, (w == 31) ? 32'h2000_0000 : 32'h0);
    delay[19:10] = 10'd2;
    ch_en[1] = 1'b1;
    pulses = 0;
    for (int j = 0; j < BL; j++) begin
      strobe(4'b0010, 1'b0);
      if (epoch[1]) pulses++;
    end
    checkVal("ch1_epoch_pulses", pulses, 1);

    // ch0 delay 0 -> 5 at cc=500 takes effect only at the epoch boundary.
    ch_en[0] = 1'b0;
    applyStimulus();
    ch_en[0] = 1'b1;
    for (int j = 0; j < 500; j++) strobe(4'b0001, 1'b0);
    delay[9:0] = 10'd5;
    for (int j = 0; j < 600; j++) strobe(4'b0001, 1'b0);

    // Random operation on all channels; ch3 starts with the out-of-range delay.
    delay[29:20] = 10'($urandom_range(0, BL - 1));
    delay[39:30] = 10'd1023;
    s_delay = 3'd7;
    ch_en = 4'hF; s_ch_en = 1'b1;
    for (int j = 0; j < 2500; j++) begin
      if ($urandom_range(0, 63) == 0) begin
        int c;
        c = $urandom_range(0, NCH - 1);
        delay[c*10 +: 10] = 10'($urandom_range(0, 1023));
      end
      if ($urandom_range(0, 63) == 0) s_delay = 3'($urandom);
      if ($urandom_range(0, 199) == 0) ch_en[$urandom_range(0, NCH - 1)] = 1'b0;
      else if ($urandom_range(0, 19) == 0) ch_en = 4'hF;
      if ($urandom_range(0, 39) == 0) begin
        wr_valid = 1'b1; wr_kind = 1'($urandom); wr_ch = 2'($urandom);
        wr_addr = 6'($urandom_range(0, wr_kind ? BMW - 1 : BCW - 1)); wr_data = $urandom;
      end
      chip_stb = 4'($urandom); s_chip_stb = 1'($urandom);
      applyStimulus();
    end
    ch_en = 4'hF;

    // Write to the very word ch2 reads on the same strobe: old data must play.
    begin
      int idx;
      strobe(4'b0100, 1'b0);
      idx = ((k[2] % BL) - dcur[2] + BL) % BL;
      wr_valid = 1'b1; wr_kind = 1'b0; wr_ch = 2'd2; wr_addr = 6'(idx / 32);
      wr_data = ~{code_bits[2][idx] ? 32'hFFFF_FFFF : 32'h0};
      strobe(4'b0100, 1'b0);
      for (int j = 0; j < 40; j++) strobe(4'b0100, 1'b0);
    end

    // Out-of-range writes are dropped and latch the error flags.
    writeBig(0, 1, 32, 32'hFFFF_FFFF);
    checkVal("wr_err_code_addr32", wr_err, 1);
    writeBig(1, 2, 47, 32'hFFFF_FFFF);
    writeSmall(0, 1, 0, 32'hFFFF_FFFF);
    checkVal("s_wr_err_bad_ch", s_wr_err, 1);
    writeSmall(1, 0, 1, 32'hFFFF_FFFF);
    for (int j = 0; j < 300; j++) strobe(4'($urandom), 1'($urandom));

    // Mid-epoch reset with enables held high.
    #2;
    rst = 1'b1;
    #1;
    checkAllZero("async_reset");
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkVal("wr_ready_after_reset2", {wr_ready, s_wr_ready}, 2'b11);
    for (int j = 0; j < 1200; j++) strobe(4'($urandom), 1'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
